// File: rtl/axi_req_dest_tracker_pkg.sv
// Shared slave-NI definitions: default configuration, destination code type and
// the per-ID tracker entry used by the request-side ordering logic.
package axi_req_dest_tracker_pkg;

  localparam int unsigned NI_ADDRESS_WIDTH = 32;
  localparam int unsigned NI_ID_WIDTH      = 4;
  localparam int unsigned NI_EXT_SLAVES    = 4;
  localparam int unsigned NI_MAX_OUTST     = 8;
  localparam int unsigned NI_DEST_W        = $clog2(NI_EXT_SLAVES + 1);
  localparam int unsigned NI_CNT_W         = $clog2(NI_MAX_OUTST + 1);

  typedef logic [NI_DEST_W-1:0] dest_t;

  // The code one past the last slave is reserved for decode-error responses.
  localparam dest_t DECERR_DEST = dest_t'(NI_EXT_SLAVES);

  typedef struct packed {
    logic [NI_CNT_W-1:0] cnt;
    dest_t               dst;
  } trk_entry_t;

endpackage

// File: rtl/axi_req_dest_tracker_onehot_to_idx.sv
// Priority encoder: index of the lowest set bit, plus a flag when no bit is set.
// Shared between the request and response sides of the NI.
module axi_onehot_to_idx #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             none_o
);

  // Scanning from the top down lets the lowest set bit win.
  always_comb begin
    idx_o  = '0;
    none_o = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o  = IDX_W'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_req_dest_tracker.sv
// Request-side destination tracker: LUT decode, same-ID ordering stall, 1-deep output register.
// Optional macro ADDR_DECERR_EN routes unmapped addresses to a decode-error destination.
module axi_req_dest_tracker
  import axi_req_dest_tracker_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = NI_ADDRESS_WIDTH,
  parameter int unsigned ID_WIDTH      = NI_ID_WIDTH,
  parameter int unsigned EXT_SLAVES    = NI_EXT_SLAVES,
  parameter int unsigned MAX_OUTST     = NI_MAX_OUTST,
  parameter int unsigned DEST_W        = $clog2(EXT_SLAVES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [ID_WIDTH-1:0]      req_id,
  output logic [ADDRESS_WIDTH-1:0] lut_address,
  input  logic [EXT_SLAVES-1:0]    lut_slaves,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_addr,
  output logic [ID_WIDTH-1:0]      out_id,
  output logic [DEST_W-1:0]        out_dest,
  output logic                     out_decerr,
  input  logic                     done_valid,
  input  logic [ID_WIDTH-1:0]      done_id
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned N_IDS = 2 ** ID_WIDTH;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);

  typedef struct packed {
    logic [CNT_W-1:0]  cnt;
    logic [DEST_W-1:0] dst;
  } entry_t;

  entry_t trk_q [N_IDS];
  entry_t trk_d [N_IDS];
  entry_t trk_sel;

  logic [N_IDS-1:0]         inc_vec, dec_vec;
  logic [DEST_W-1:0]        hit_idx, req_dest;
  logic                     no_hit, req_decerr, blocked, accept;
  logic                     out_valid_q;
  logic [ADDRESS_WIDTH-1:0] out_addr_q;
  logic [ID_WIDTH-1:0]      out_id_q;
  logic [DEST_W-1:0]        out_dest_q;

  assign lut_address = req_addr;

  axi_onehot_to_idx #(
    .N     (EXT_SLAVES),
    .IDX_W (DEST_W)
  ) u_dec (
    .vec_i  (lut_slaves),
    .idx_o  (hit_idx),
    .none_o (no_hit)
  );

`ifdef ADDR_DECERR_EN
  localparam logic [DEST_W-1:0] ERR_DEST = DEST_W'(EXT_SLAVES);
  assign req_dest   = no_hit ? ERR_DEST : hit_idx;
  assign req_decerr = no_hit;
`else
  assign req_dest   = no_hit ? '0 : hit_idx;
  assign req_decerr = 1'b0;
`endif

  // A request waits while its ID is saturated or still owes responses from another slave.
  assign trk_sel   = trk_q[req_id];
  assign blocked   = (trk_sel.cnt == CNT_FULL) |
                     ((trk_sel.cnt != '0) & (trk_sel.dst != req_dest));
  assign req_ready = ~blocked & (~out_valid_q | out_ready);
  assign accept    = req_valid & req_ready;

  always_comb begin
    for (int i = 0; i < N_IDS; i++) begin
      trk_d[i]   = trk_q[i];
      inc_vec[i] = accept && (req_id == ID_WIDTH'(i));
      dec_vec[i] = done_valid && (done_id == ID_WIDTH'(i)) && (trk_q[i].cnt != '0);
      if (inc_vec[i]) trk_d[i].dst = req_dest;
      if (inc_vec[i] && !dec_vec[i])      trk_d[i].cnt = trk_q[i].cnt + CNT_W'(1);
      else if (dec_vec[i] && !inc_vec[i]) trk_d[i].cnt = trk_q[i].cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IDS; i++) trk_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_id_q    <= '0;
      out_dest_q  <= '0;
    end else begin
      trk_q <= trk_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_addr_q  <= req_addr;
        out_id_q    <= req_id;
        out_dest_q  <= req_dest;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef ADDR_DECERR_EN
  logic out_decerr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      out_decerr_q <= 1'b0;
    else if (accept) out_decerr_q <= req_decerr;
  end
  assign out_decerr = out_decerr_q;
`else
  assign out_decerr = 1'b0;
  logic unused_decerr;
  assign unused_decerr = req_decerr;
`endif

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_id    = out_id_q;
  assign out_dest  = out_dest_q;

  // A completion for an ID with nothing outstanding indicates an upstream protocol bug.
  assert property (@(posedge clk) disable iff (!rst_n)
                   done_valid |-> (trk_q[done_id].cnt != '0));

endmodule

// File: tb/tb_axi_req_dest_tracker.sv
// Randomized and directed bench for axi_req_dest_tracker against a transaction-list model.
// Honours ADDR_DECERR_EN the same way as the design.
module tb_axi_req_dest_tracker;

  localparam int MAXO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, out_valid, out_ready, out_decerr, done_valid;
  logic [31:0] req_addr, lut_address, out_addr;
  logic [3:0]  req_id, out_id, done_id, lut_slaves;
  logic [2:0]  out_dest;

  typedef struct {
    int id;
    int dest;
  } txn_t;

  txn_t        pend[$];
  int          testCount = 0;
  int          failCount = 0;
  logic        mValid;
  logic [31:0] mAddr;
  logic [3:0]  mId;
  int          mDest;
  logic        mErr;

  always #5 clk = ~clk;

  // Address map stub: top nibble selects the slave; C and F overlap two slaves.
  function automatic logic [3:0] lutOf(input logic [31:0] a);
    case (a[31:28])
      4'h0:    return 4'b0001;
      4'h1:    return 4'b0010;
      4'h2:    return 4'b0100;
      4'h3:    return 4'b1000;
      4'hC:    return 4'b1100;
      4'hF:    return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  always_comb lut_slaves = lutOf(lut_address);

  axi_req_dest_tracker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_id      (req_id),
    .lut_address (lut_address),
    .lut_slaves  (lut_slaves),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_id      (out_id),
    .out_dest    (out_dest),
    .out_decerr  (out_decerr),
    .done_valid  (done_valid),
    .done_id     (done_id)
  );

  function automatic int destOf(input logic [31:0] a);
    logic [3:0] v;
    v = lutOf(a);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
`ifdef ADDR_DECERR_EN
    return 4;
`else
    return 0;
`endif
  endfunction

  function automatic logic errOf(input logic [31:0] a);
`ifdef ADDR_DECERR_EN
    return lutOf(a) == 4'b0000;
`else
    return (a[0] & 1'b0);
`endif
  endfunction

  // sel 0..3 = slave, 4 = unmapped, 5 = overlap {3,2}, 6 = overlap {3,1}
  function automatic logic [31:0] addrFor(input int sel);
    logic [3:0] n;
    case (sel)
      0, 1, 2, 3: n = 4'(sel);
      4:          n = 4'h7;
      5:          n = 4'hC;
      default:    n = 4'hF;
    endcase
    return {n, 28'($urandom)};
  endfunction

  function automatic int outstanding(input int id);
    int n = 0;
    foreach (pend[k]) if (pend[k].id == id) n++;
    return n;
  endfunction

  function automatic int lastDest(input int id);
    int d = -1;
    foreach (pend[k]) if (pend[k].id == id) d = pend[k].dest;
    return d;
  endfunction

  function automatic void retire(input int id);
    for (int k = 0; k < pend.size(); k++) begin
      if (pend[k].id == id) begin
        pend.delete(k);
        return;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("out_valid",  64'(out_valid),  64'(mValid));
    chk("out_addr",   64'(out_addr),   64'(mAddr));
    chk("out_id",     64'(out_id),     64'(mId));
    chk("out_dest",   64'(out_dest),   64'(mDest));
    chk("out_decerr", 64'(out_decerr), 64'(mErr));
  endtask

  // One clock cycle: drive at posedge+1, check ready at negedge, check outputs at next posedge+1.
  task automatic applyStimulus(input int v, input logic [31:0] a, input int id,
                               input int ordy, input int dv, input int did);
    logic expReady, acc, dvEff;
    int   d, n;
    dvEff      = (dv != 0) && (outstanding(did) > 0);
    req_valid  = (v != 0);
    req_addr   = a;
    req_id     = 4'(id);
    out_ready  = (ordy != 0);
    done_valid = dvEff;
    done_id    = 4'(did);
    #4;
    d = destOf(a);
    n = outstanding(id);
    expReady = !((n == MAXO) || (n != 0 && lastDest(id) != d)) && (!mValid || (ordy != 0));
    chk("req_ready", 64'(req_ready), 64'(expReady));
    acc = (v != 0) && expReady;
    @(posedge clk);
    #1;
    if (acc) begin
      mValid = 1'b1;
      mAddr  = a;
      mId    = 4'(id);
      mDest  = d;
      mErr   = errOf(a);
    end else if (ordy != 0) begin
      mValid = 1'b0;
    end
    if (dvEff) retire(did);
    if (acc) pend.push_back('{id: id, dest: d});
    checkOutput();
  endtask

  task automatic modelReset();
    pend.delete();
    mValid = 1'b0;
    mAddr  = '0;
    mId    = '0;
    mDest  = 0;
    mErr   = 1'b0;
  endtask

  initial begin
    req_valid  = 1'b0;
    req_addr   = '0;
    req_id     = '0;
    out_ready  = 1'b0;
    done_valid = 1'b0;
    done_id    = '0;
    modelReset();

    #3;
    checkOutput();
    chk("rst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single request to slave 2");
    applyStimulus(1, addrFor(2), 3, 1, 0, 0);
    chk("t1_dest", 64'(out_dest), 64'd2);
    applyStimulus(0, 32'h0, 0, 1, 1, 3);
    applyStimulus(1, addrFor(0), 3, 1, 0, 0);
    chk("t1_redirect", 64'(out_dest), 64'd0);
    applyStimulus(0, 32'h0, 0, 1, 1, 3);

    $display("[TB] same-ID redirect stall");
    applyStimulus(1, addrFor(0), 1, 1, 0, 0);
    repeat (3) applyStimulus(1, addrFor(1), 1, 1, 0, 0);
    chk("t2_stalled", 64'(out_valid), 64'd0);
    applyStimulus(1, addrFor(1), 1, 1, 1, 1);
    applyStimulus(1, addrFor(1), 1, 1, 0, 0);
    chk("t2_dest", 64'(out_dest), 64'd1);
    applyStimulus(0, 32'h0, 0, 1, 1, 1);

    $display("[TB] outstanding limit");
    repeat (MAXO) applyStimulus(1, addrFor(3), 5, 1, 0, 0);
    repeat (2) applyStimulus(1, addrFor(3), 5, 1, 0, 0);
    applyStimulus(1, addrFor(3), 5, 1, 1, 5);
    applyStimulus(1, addrFor(3), 5, 1, 0, 0);
    chk("t3_ninth", 64'(out_valid), 64'd1);
    repeat (MAXO) applyStimulus(0, 32'h0, 0, 1, 1, 5);

    $display("[TB] unmapped and overlapping addresses");
    applyStimulus(1, addrFor(4), 6, 1, 0, 0);
`ifdef ADDR_DECERR_EN
    chk("t4_err_dest", 64'(out_dest), 64'd4);
    chk("t4_err_flag", 64'(out_decerr), 64'd1);
`else
    chk("t4_err_dest", 64'(out_dest), 64'd0);
    chk("t4_err_flag", 64'(out_decerr), 64'd0);
`endif
    applyStimulus(1, addrFor(5), 7, 1, 0, 0);
    chk("t4_overlap", 64'(out_dest), 64'd2);
    applyStimulus(0, 32'h0, 0, 1, 1, 6);
    applyStimulus(0, 32'h0, 0, 1, 1, 7);

    $display("[TB] output backpressure then streaming");
    applyStimulus(1, addrFor(0), 8, 0, 0, 0);
    repeat (5) applyStimulus(1, addrFor(0), 8, 0, 0, 0);
    repeat (4) applyStimulus(1, addrFor(0), 8, 1, 0, 0);
    repeat (5) applyStimulus(0, 32'h0, 0, 1, 1, 8);

    $display("[TB] reset while holding a request");
    repeat (3) applyStimulus(1, addrFor(1), 2, 1, 0, 0);
    applyStimulus(0, 32'h0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, addrFor(3), 2, 1, 0, 0);
    chk("t6_accept", 64'(out_valid), 64'd1);
    chk("t6_dest", 64'(out_dest), 64'd3);
    applyStimulus(0, 32'h0, 0, 1, 1, 2);

    $display("[TB] random traffic");
    repeat (400) begin
      int did;
      did = (pend.size() > 0) ? pend[$urandom_range(0, pend.size() - 1)].id : 0;
      applyStimulus(($urandom_range(0, 3) != 0) ? 1 : 0,
                    addrFor($urandom_range(0, 6)),
                    $urandom_range(0, 3),
                    ($urandom_range(0, 9) < 7) ? 1 : 0,
                    $urandom_range(0, 1),
                    did);
    end
    for (int k = 0; k < 64 && pend.size() > 0; k++)
      applyStimulus(0, 32'h0, 0, 1, 1, pend[0].id);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
